// File: rtl/mel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mel_pkg
// Purpose  : Shared widths and log2 fixed-point format for the mel serializer.
// Revision : 1.0
// ============================================================================
package mel_pkg;

    localparam int DATA_W     = 16;
    localparam int MEL_BANDS  = 40;
    localparam int LOG_INT_W  = 4;
    localparam int LOG_FRAC_W = 12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } beat_state_t;

endpackage
`default_nettype wire

// File: rtl/mel_frame_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : mel_frame_serializer_if
// Purpose  : Frame-in / beat-out bundle; slave is the serializer side.
// Revision : 1.0
// ============================================================================
interface mel_frame_serializer_if
    import mel_pkg::*;
#(
    parameter int NUM_BANDS = MEL_BANDS,
    parameter int OUT_WIDTH = 1,
    parameter int IDX_W     = 16
);
    logic [NUM_BANDS*DATA_W-1:0] in;
    logic                        s_valid;
    logic                        s_ready;
    logic                        log_en;
    logic [OUT_WIDTH*DATA_W-1:0] out;
    logic                        m_valid;
    logic                        m_ready;
    logic                        m_last;
    logic [IDX_W-1:0]            frame_idx;

    modport slave (
        input  in, s_valid, log_en, m_ready,
        output s_ready, out, m_valid, m_last, frame_idx
    );

    modport master (
        output in, s_valid, log_en, m_ready,
        input  s_ready, out, m_valid, m_last, frame_idx
    );
endinterface
`default_nettype wire

// File: rtl/mel_frame_serializer_log2_fx.sv
`default_nettype none
// ============================================================================
// Module   : log2_fx
// Purpose  : Combinational log2 in {int[3:0], frac[11:0]}, truncated mantissa.
// Revision : 1.0
// ============================================================================
module log2_fx
    import mel_pkg::*;
(
    input  logic [DATA_W-1:0] x_i,
    output logic [DATA_W-1:0] y_o
);
    logic [LOG_INT_W-1:0] w_pos;
    logic [DATA_W-1:0]    w_aligned;

    always_comb begin
        w_pos = '0;
        for (int i = 1; i < DATA_W; i++) begin
            if (x_i[i]) w_pos = LOG_INT_W'(i);
        end
        // Leading one lands on the MSB; bits below it become the fraction.
        w_aligned = x_i << (LOG_INT_W'(DATA_W - 1) - w_pos);
        y_o       = {w_pos, w_aligned[DATA_W-2 -: LOG_FRAC_W]};
    end
endmodule
`default_nettype wire

// File: rtl/mel_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mel_frame_serializer
// Purpose  : Double-buffered mel frame to AXI-Stream beat serializer.
// Revision : 1.0
// ============================================================================
module mel_frame_serializer
    import mel_pkg::*;
#(
    parameter int NUM_BANDS = MEL_BANDS,
    parameter int OUT_WIDTH = 1,
    parameter int IDX_W     = 16
)(
    input  logic                   clk,
    input  logic                   reset,
    mel_frame_serializer_if.slave  bus
);
    localparam int BEATS   = (NUM_BANDS + OUT_WIDTH - 1) / OUT_WIDTH;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int FRAME_W = NUM_BANDS * DATA_W;
    localparam int LANE_W  = OUT_WIDTH * DATA_W;
    localparam int PAD_W   = BEATS * LANE_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    beat_state_t          state_q,     state_d;
    logic [BEAT_W-1:0]    beat_q,      beat_d;
    logic [FRAME_W-1:0]   act_data_q,  act_data_d;
    logic [IDX_W-1:0]     act_idx_q,   act_idx_d;
    logic [FRAME_W-1:0]   pend_data_q, pend_data_d;
    logic [IDX_W-1:0]     pend_idx_q,  pend_idx_d;
    logic                 pend_full_q, pend_full_d;
    logic [IDX_W-1:0]     acc_q,       acc_d;

    logic [FRAME_W-1:0]   w_log;
    logic [FRAME_W-1:0]   w_capture;
    logic [PAD_W-1:0]     w_pad;
    logic [LANE_W-1:0]    w_beats [BEATS];
    logic                 w_accept;
    logic                 w_beat_hs;
    logic                 w_last_hs;

    genvar gb;
    generate
        for (gb = 0; gb < NUM_BANDS; gb++) begin : g_log
            log2_fx u_log2 (
                .x_i (bus.in[gb*DATA_W +: DATA_W]),
                .y_o (w_log[gb*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign w_capture = bus.log_en ? w_log : bus.in;
    assign w_accept  = bus.s_valid & ~pend_full_q;
    assign w_beat_hs = (state_q == ST_SEND) & bus.m_ready;
    assign w_last_hs = w_beat_hs & (beat_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        act_data_d  = act_data_q;
        act_idx_d   = act_idx_q;
        pend_data_d = pend_data_q;
        pend_idx_d  = pend_idx_q;
        pend_full_d = pend_full_q;
        acc_d       = acc_q;

        if (w_accept) acc_d = acc_q + IDX_W'(1);

        if (w_last_hs) begin
            beat_d = '0;
            // A waiting frame has priority; accept is blocked while it is full.
            if (pend_full_q) begin
                act_data_d  = pend_data_q;
                act_idx_d   = pend_idx_q;
                pend_full_d = 1'b0;
            end else if (w_accept) begin
                act_data_d = w_capture;
                act_idx_d  = acc_q;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            if (w_beat_hs) beat_d = beat_q + BEAT_W'(1);
            if (w_accept) begin
                if (state_q == ST_IDLE) begin
                    act_data_d = w_capture;
                    act_idx_d  = acc_q;
                    state_d    = ST_SEND;
                    beat_d     = '0;
                end else begin
                    pend_data_d = w_capture;
                    pend_idx_d  = acc_q;
                    pend_full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            act_data_q  <= '0;
            act_idx_q   <= '0;
            pend_data_q <= '0;
            pend_idx_q  <= '0;
            pend_full_q <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            act_data_q  <= act_data_d;
            act_idx_q   <= act_idx_d;
            pend_data_q <= pend_data_d;
            pend_idx_q  <= pend_idx_d;
            pend_full_q <= pend_full_d;
            acc_q       <= acc_d;
        end
    end

    // Bands past NUM_BANDS read as zero through the widening cast.
    assign w_pad = PAD_W'(act_data_q);

    generate
        for (gb = 0; gb < BEATS; gb++) begin : g_beat
            assign w_beats[gb] = w_pad[gb*LANE_W +: LANE_W];
        end
    endgenerate

    assign bus.s_ready   = ~pend_full_q;
    assign bus.m_valid   = (state_q == ST_SEND);
    assign bus.m_last    = (state_q == ST_SEND) && (beat_q == LAST_BEAT);
    assign bus.out       = (state_q == ST_SEND) ? w_beats[beat_q] : '0;
    assign bus.frame_idx = act_idx_q;
endmodule
`default_nettype wire

// File: tb/tb_mel_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mel_frame_serializer
// Purpose  : Directed/table bench for three serializer configurations.
// Revision : 1.0
// ============================================================================
module tb_mel_frame_serializer;
    import mel_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mel_frame_serializer_if #(.NUM_BANDS(40), .OUT_WIDTH(8),  .IDX_W(2))  ifa ();
    mel_frame_serializer_if #(.NUM_BANDS(40), .OUT_WIDTH(16), .IDX_W(16)) ifb ();
    mel_frame_serializer_if #(.NUM_BANDS(4),  .OUT_WIDTH(4),  .IDX_W(16)) ifc ();

    mel_frame_serializer #(.NUM_BANDS(40), .OUT_WIDTH(8),  .IDX_W(2))  u_a (.clk(clk), .reset(reset), .bus(ifa));
    mel_frame_serializer #(.NUM_BANDS(40), .OUT_WIDTH(16), .IDX_W(16)) u_b (.clk(clk), .reset(reset), .bus(ifb));
    mel_frame_serializer #(.NUM_BANDS(4),  .OUT_WIDTH(4),  .IDX_W(16)) u_c (.clk(clk), .reset(reset), .bus(ifc));

    typedef struct {
        logic [127:0] data;
        logic         last;
        logic [1:0]   idx;
    } beat_t;

    typedef struct {
        logic [63:0] bands;
        logic        log_en;
        logic [63:0] exp;
    } vec_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    beat_t       exp_q[$];
    logic [1:0]  tb_acc = 2'd0;
    int          a_frame = 0;
    logic        rnd_en = 1'b0;
    logic        seen_sready_low = 1'b0;
    logic        prev_stall = 1'b0;
    logic [127:0] prev_out;
    logic        prev_last;
    logic [1:0]  prev_idx;
    vec_t        tbl [4];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] bval(input int fr, input int n);
        return 16'(fr * 256 + n + 1);
    endfunction

    function automatic logic [127:0] a_beat(input int fr, input int b);
        logic [127:0] r;
        for (int l = 0; l < 8; l++) r[l*16 +: 16] = bval(fr, b * 8 + l);
        return r;
    endfunction

    // Scoreboard for instance A, evaluated between edges.
    task automatic monitor_a();
        beat_t e;
        if (!reset) begin
            exp_q.delete();
            tb_acc     = 2'd0;
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            check("hold_valid", 256'(ifa.m_valid), 256'(1'b1));
            check("hold_out", 256'(ifa.out), 256'(prev_out));
            check("hold_last", 256'(ifa.m_last), 256'(prev_last));
            check("hold_idx", 256'(ifa.frame_idx), 256'(prev_idx));
        end
        if (ifa.s_valid && !ifa.s_ready) seen_sready_low = 1'b1;
        if (ifa.m_valid && ifa.m_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got out %h with no beat expected", ifa.out);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 256'(ifa.out), 256'(e.data));
                check("beat_last", 256'(ifa.m_last), 256'(e.last));
                check("beat_idx", 256'(ifa.frame_idx), 256'(e.idx));
            end
        end
        if (ifa.s_valid && ifa.s_ready) begin
            for (int b = 0; b < 5; b++) begin
                e.data = a_beat(a_frame, b);
                e.last = (b == 4);
                e.idx  = tb_acc;
                exp_q.push_back(e);
            end
            tb_acc = tb_acc + 2'd1;
        end
        prev_stall = ifa.m_valid && !ifa.m_ready;
        prev_out   = ifa.out;
        prev_last  = ifa.m_last;
        prev_idx   = ifa.frame_idx;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_a();
        @(posedge clk);
        #1;
        if (rnd_en) ifa.m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_a(input int fr);
        logic ok;
        logic accepted;
        accepted = 1'b0;
        for (int n = 0; n < 40; n++) ifa.in[n*16 +: 16] = bval(fr, n);
        a_frame     = fr;
        ifa.s_valid = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            ok = ifa.s_ready;
            tick();
            accepted = ok;
        end
        if (!accepted) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: frame %0d not accepted, expected acceptance within 200 cycles", fr);
        end
        ifa.s_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        logic [255:0] eb;
        int n;

        ifa.in = '0; ifa.s_valid = 0; ifa.log_en = 0; ifa.m_ready = 0;
        ifb.in = '0; ifb.s_valid = 0; ifb.log_en = 0; ifb.m_ready = 0;
        ifc.in = '0; ifc.s_valid = 0; ifc.log_en = 0; ifc.m_ready = 0;

        tbl[0] = '{64'h8000_0003_0001_0000, 1'b1, 64'hF000_1800_0000_0000};
        tbl[1] = '{64'h8000_0003_0001_0000, 1'b0, 64'h8000_0003_0001_0000};
        tbl[2] = '{64'hFFFF_1234_00FF_0002, 1'b1, 64'hFFFF_C234_7FE0_1000};
        tbl[3] = '{64'h0010_0C00_0400_0005, 1'b1, 64'h4000_B800_A000_2400};

        repeat (3) tick();
        check("rst_a_valid", 256'(ifa.m_valid), 256'(1'b0));
        check("rst_a_last", 256'(ifa.m_last), 256'(1'b0));
        check("rst_a_out", 256'(ifa.out), 256'(0));
        check("rst_a_idx", 256'(ifa.frame_idx), 256'(0));
        check("rst_b_out", 256'(ifb.out), 256'(0));
        check("rst_c_valid", 256'(ifc.m_valid), 256'(1'b0));
        reset = 1'b1;
        tick();
        check("rst_a_sready", 256'(ifa.s_ready), 256'(1'b1));
        check("rst_b_sready", 256'(ifb.s_ready), 256'(1'b1));
        check("rst_c_sready", 256'(ifc.s_ready), 256'(1'b1));

        // Single frame, bands 1..40, eight lanes.
        ifa.m_ready = 1'b1;
        send_a(0);
        check("lat_valid", 256'(ifa.m_valid), 256'(1'b1));
        check("lat_beat0", 256'(ifa.out), 256'(a_beat(0, 0)));
        check("lat_idx", 256'(ifa.frame_idx), 256'(0));
        check("lat_last", 256'(ifa.m_last), 256'(1'b0));
        repeat (4) tick();
        check("single_beat4", 256'(ifa.out), 256'(a_beat(0, 4)));
        check("single_last", 256'(ifa.m_last), 256'(1'b1));
        tick();
        check("single_idle", 256'(ifa.m_valid), 256'(1'b0));
        check("single_drained", 256'(exp_q.size()), 256'(0));

        // Zero padding on the final 16-lane beat.
        ifb.m_ready = 1'b1;
        for (int k = 0; k < 40; k++) ifb.in[k*16 +: 16] = 16'(k + 1);
        ifb.s_valid = 1'b1;
        tick();
        ifb.s_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            eb = '0;
            for (int l = 0; l < 16; l++) begin
                n = b * 16 + l;
                eb[l*16 +: 16] = (n < 40) ? 16'(n + 1) : 16'h0000;
            end
            check("pad_valid", 256'(ifb.m_valid), 256'(1'b1));
            check("pad_out", ifb.out, eb);
            check("pad_last", 256'(ifb.m_last), 256'(b == 2));
            tick();
        end
        check("pad_idle", 256'(ifb.m_valid), 256'(1'b0));

        // Log/raw table on a single-beat configuration.
        ifc.m_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            check("tbl_sready", 256'(ifc.s_ready), 256'(1'b1));
            ifc.in      = tbl[t].bands;
            ifc.log_en  = tbl[t].log_en;
            ifc.s_valid = 1'b1;
            tick();
            ifc.s_valid = 1'b0;
            ifc.in      = ~tbl[t].bands;
            ifc.log_en  = ~tbl[t].log_en;
            check("tbl_out", 256'(ifc.out), 256'(tbl[t].exp));
            check("tbl_last", 256'(ifc.m_last), 256'(1'b1));
            check("tbl_valid", 256'(ifc.m_valid), 256'(1'b1));
            tick();
            check("tbl_idle", 256'(ifc.m_valid), 256'(1'b0));
        end

        // Backpressure: three frames back-to-back, random m_ready.
        pulse_reset();
        seen_sready_low = 1'b0;
        rnd_en = 1'b1;
        send_a(1);
        send_a(2);
        send_a(3);
        for (int i = 0; i < 300 && (exp_q.size() != 0 || ifa.m_valid); i++) tick();
        rnd_en = 1'b0;
        ifa.m_ready = 1'b1;
        check("bp_drained", 256'(exp_q.size()), 256'(0));
        check("bp_sready_dropped", 256'(seen_sready_low), 256'(1'b1));

        // Throughput: a frame every five cycles, index wraps 3 -> 0.
        pulse_reset();
        for (int f = 0; f < 6; f++) begin
            send_a(10 + f);
            for (int j = 0; j < 5; j++) begin
                check("tp_valid", 256'(ifa.m_valid), 256'(1'b1));
                if (j < 4) tick();
            end
        end
        repeat (2) tick();
        check("tp_drained", 256'(exp_q.size()), 256'(0));

        // Reset during beat 2 with the pending slot occupied.
        pulse_reset();
        send_a(20);
        send_a(21);
        tick();
        check("mid_beat2", 256'(ifa.out), 256'(a_beat(20, 2)));
        check("mid_sready_full", 256'(ifa.s_ready), 256'(1'b0));
        reset = 1'b0;
        tick();
        check("mid_rst_valid", 256'(ifa.m_valid), 256'(1'b0));
        check("mid_rst_last", 256'(ifa.m_last), 256'(1'b0));
        check("mid_rst_sready", 256'(ifa.s_ready), 256'(1'b1));
        reset = 1'b1;
        send_a(22);
        check("post_rst_beat0", 256'(ifa.out), 256'(a_beat(22, 0)));
        check("post_rst_idx", 256'(ifa.frame_idx), 256'(0));
        repeat (6) tick();
        check("post_rst_drained", 256'(exp_q.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mel_frame_serializer.md
# mel_frame_serializer

Parametrised successor to the fixed filter-bank output reshaper. It accepts one complete mel frame of NUM_BANDS parallel 16-bit energies from the filter bank and streams it out as AXI-Stream beats OUT_WIDTH lanes wide. The last beat of each frame carries tlast, and the last beat is zero-padded when NUM_BANDS is not a multiple of OUT_WIDTH. New over the old reshaper:
- a per-frame optional log2 compression mode;
- a double buffer, so frames pass back-to-back with no bubble;
- a wrapping frame index that travels with every beat.

It sits between filter_bank and the mfcc top-level m_axis port.

## Interface
- NUM_BANDS, 40, number of mel bands per frame (1..64)
- OUT_WIDTH, 1, lanes per output beat (1..NUM_BANDS)
- IDX_W, 16, width of frame index counter
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-low reset
- in  in  16 x NUM_BANDS  frame energies, unsigned
- s_valid  in  1  frame on `in` is valid
- s_ready  out  1  block can accept a frame this cycle
- log_en  in  1  compression mode, sampled with the frame
- out  out  16 x OUT_WIDTH  output lanes
- m_valid  out  1  beat valid
- m_ready  in  1  downstream accepts beat
- m_last  out  1  final beat of frame
- frame_idx  out  IDX_W  index of the frame being output

## Operation
- BEATS = ceil(NUM_BANDS/OUT_WIDTH). Beat b lane l carries band b*OUT_WIDTH+l. Bands ≥ NUM_BANDS output 0x0000.
- Two frame slots:
  - ACTIVE: being serialised.
  - PENDING: captured and waiting.
- s_ready = !PENDING_full. A frame is accepted when s_valid & s_ready. It is stored with log_en and the current accept counter.
- Accept when ACTIVE is empty, or when ACTIVE is emptying this cycle (last beat handshaked): the frame goes directly to ACTIVE. Otherwise it goes to PENDING.
- When ACTIVE's last beat handshakes and PENDING is full, PENDING moves to ACTIVE on the same edge, and PENDING clears.
- Beat counter states: IDLE (ACTIVE empty) and SEND(b).
  - SEND(b) -> SEND(b+1) on m_valid&m_ready.
  - SEND(BEATS-1) -> SEND(0) if a next frame is available, else IDLE.
- Hold rule: out, m_last and frame_idx stay stable while m_valid & !m_ready.
- log_en=1: each band x maps to log2 fixed point {p[3:0], f[11:0]}.
  - p = index of the leading one.
  - f = the bits below the leading one, left-aligned into 12 bits, zero-filled on the right, truncated.
  - x=0 and x=1 both map to 0x0000. Examples: x=0x8000 -> 0xF000; x=0x0003 -> 0x1800.
- log_en=0: out = in unchanged.
- frame_idx: counter of accepted frames. It is 0 for the first frame after reset and wraps at 2^IDX_W.
- Padding lanes are zero in both modes.

## Timing
- Reset (reset=0 at an edge) sets:
  - m_valid=0, m_last=0, out=0, frame_idx=0;
  - both slots empty, beat counter 0, accept counter 0.
- s_ready=1 from the first edge with reset=1.
- Reset mid-frame discards ACTIVE and PENDING without emitting m_last.
- Latency: a frame accepted at edge k into an empty block gives m_valid=1 with beat 0 after edge k (visible in cycle k+1).
- Throughput: with m_ready held at 1, exactly BEATS cycles per frame. There is no idle cycle between frames if the next frame was accepted before the last beat.
- If BEATS=1, every beat has m_last=1. s_ready may stay 1 continuously with m_ready=1.
- Compression is registered at capture. The output path has no combinational path from `in` to `out`.
- s_ready depends only on registered state, with no combinational path from m_ready.

## Structure
- Package mel_pkg holds:
  - DATA_W=16;
  - MEL_BANDS=40 (default for NUM_BANDS);
  - the log2 output format constants (4 integer bits, 12 fraction bits).
- Sub-module log2_fx: combinational 16-bit leading-one detect and left-align. It is instantiated NUM_BANDS times at the capture input.
- Top holds the two slot registers (data, mode-applied values, frame index), the slot-full flags, the beat counter and the output mux.

## Test plan
- Single frame, NUM_BANDS=40, OUT_WIDTH=8, log_en=0, bands=1..40, m_ready=1 -> 5 beats. Beat 0 = 1..8; beat 4 = 33..40 with m_last; frame_idx=0; m_valid one cycle after accept.
- Padding, OUT_WIDTH=16, bands=1..40 -> 3 beats. Beat 2 lanes 0-7 = 33..40, lanes 8-15 = 0, m_last on beat 2 only.
- Log mode, OUT_WIDTH=4, NUM_BANDS=4, bands {0x0000, 0x0001, 0x0003, 0x8000}, log_en=1 -> single beat {0x0000, 0x0000, 0x1800, 0xF000}, m_last=1.
- Backpressure, 3 frames offered back-to-back, m_ready random 50%:
  - all beats are in order and stable while stalled;
  - s_ready drops once both slots are full;
  - frame_idx = 0, 1, 2.
- Back-to-back throughput, m_ready=1, frames every 5 cycles, OUT_WIDTH=8 -> m_valid continuously high with no bubble. IDX_W=2 wraps frame_idx 3 -> 0.
- Reset at beat 2 of a frame with PENDING full -> next cycle m_valid=0, s_ready=1. The next frame is output from beat 0 with frame_idx=0.
